control_unit: RTL and testbench

Microprogram-free hardwired sequencer for the accumulator datapath. Fetches 8-bit opcodes through the IR, decodes them and drives the 16-bit `control` word for every fetch/execute cycle. That word carries bus source select, register loads, PC increment, ALU op and DRAM write. Sits beside the datapath; its only inputs from it are `ir_out[7:0]` and the AC zero flag.

---
 rtl/control_unit.sv | 192 +++++++++++++++++++
 tb/tb_control_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the accumulator datapath.
// Define CU_WAIT_STATE_EN to insert a WAIT cycle ahead of every IRAM/DRAM read state.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ir_out,
  input  logic        z,
  output logic [15:0] control,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LD1    = 4'd3,
    LD2    = 4'd4,
    LD3    = 4'd5,
    ST1    = 4'd6,
    ST2    = 4'd7,
    ST3    = 4'd8,
    EXEC   = 4'd9,
    JMP    = 4'd10,
    WAIT   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_DR   = 3'd2;
  localparam logic [2:0] BUS_R    = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_DRAM = 3'd5;
  localparam logic [2:0] BUS_IRAM = 3'd6;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;
  localparam logic [1:0] ALU_INC  = 2'b11;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_INAC = 8'h07;
  localparam logic [7:0] OP_JUMP = 8'h08;
  localparam logic [7:0] OP_JMPZ = 8'h09;
  localparam logic [7:0] OP_HALT = 8'hFF;

  state_t state_q, state_d, nxt;
  logic   illegal_q, illegal_d;
`ifdef CU_WAIT_STATE_EN
  state_t tgt_q, tgt_d;
`endif

  logic [2:0] bus;
  logic [1:0] alu_op;
  logic       r_ld, ar_ld, dr_ld, ac_ld, pc_ld, pc_inc, ir_ld, dram_wr;

  always_comb begin
    nxt       = state_q;
    illegal_d = 1'b0;
    bus       = BUS_NONE;
    alu_op    = ALU_ADD;
    r_ld      = 1'b0;
    ar_ld     = 1'b0;
    dr_ld     = 1'b0;
    ac_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    ir_ld     = 1'b0;
    dram_wr   = 1'b0;
    case (state_q)
      IDLE: if (start) nxt = FETCH;
      FETCH: begin
        // AR also captures the opcode word; LD1/ST1 overwrite it before any use.
        bus    = BUS_IRAM;
        ir_ld  = 1'b1;
        ar_ld  = 1'b1;
        pc_inc = 1'b1;
        nxt    = DECODE;
      end
      DECODE: begin
        case (ir_out)
          OP_NOP:  nxt = FETCH;
          OP_LDAC: nxt = LD1;
          OP_STAC: nxt = ST1;
          OP_MVAC, OP_MOVR, OP_ADD, OP_SUB, OP_INAC: nxt = EXEC;
          OP_JUMP, OP_JMPZ: nxt = JMP;
          OP_HALT: nxt = HALT;
          default: begin
            illegal_d = 1'b1;
            nxt       = FETCH;
          end
        endcase
      end
      LD1, ST1: begin
        bus    = BUS_IRAM;
        ar_ld  = 1'b1;
        pc_inc = 1'b1;
        nxt    = (state_q == LD1) ? LD2 : ST2;
      end
      LD2: begin
        bus   = BUS_DRAM;
        dr_ld = 1'b1;
        nxt   = LD3;
      end
      LD3: begin
        bus    = BUS_DR;
        alu_op = ALU_PASS;
        ac_ld  = 1'b1;
        nxt    = FETCH;
      end
      ST2: begin
        bus   = BUS_AC;
        dr_ld = 1'b1;
        nxt   = ST3;
      end
      ST3: begin
        bus     = BUS_DR;
        dram_wr = 1'b1;
        nxt     = FETCH;
      end
      EXEC: begin
        case (ir_out)
          OP_MVAC: begin bus = BUS_AC; r_ld = 1'b1; end
          OP_MOVR: begin bus = BUS_R; alu_op = ALU_PASS; ac_ld = 1'b1; end
          OP_ADD:  begin bus = BUS_R; alu_op = ALU_ADD;  ac_ld = 1'b1; end
          OP_SUB:  begin bus = BUS_R; alu_op = ALU_SUB;  ac_ld = 1'b1; end
          OP_INAC: begin alu_op = ALU_INC; ac_ld = 1'b1; end
          default: ;
        endcase
        nxt = FETCH;
      end
      JMP: begin
        // Not-taken JMPZ steps PC past the operand word instead of loading it.
        if (ir_out == OP_JUMP || z) begin
          bus   = BUS_IRAM;
          pc_ld = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
        nxt = FETCH;
      end
`ifdef CU_WAIT_STATE_EN
      WAIT: nxt = tgt_q;
`else
      WAIT: nxt = IDLE;
`endif
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase

    state_d = nxt;
`ifdef CU_WAIT_STATE_EN
    tgt_d = tgt_q;
    if (state_q != WAIT &&
        (nxt == FETCH || nxt == LD1 || nxt == LD2 || nxt == ST1 || nxt == JMP)) begin
      state_d = WAIT;
      tgt_d   = nxt;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
`ifdef CU_WAIT_STATE_EN
      tgt_q     <= IDLE;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
`ifdef CU_WAIT_STATE_EN
      tgt_q     <= tgt_d;
`endif
    end
  end

  assign control = {3'b000, dram_wr, alu_op, ir_ld, pc_inc, pc_ld, ac_ld,
                    dr_ld, ar_ld, r_ld, bus};
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: checks control words, illegal pulse, halt and reset.
module tb_control_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ir_out;
  logic        z;
  logic [15:0] control;
  logic        halted;
  logic        illegal;
  logic [3:0]  state_o;

  int errors;
  int checks;

  control_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ir_out  (ir_out),
    .z       (z),
    .control (control),
    .halted  (halted),
    .illegal (illegal),
    .state_o (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    ir_out = 8'h00;
    z      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (control !== 16'h0000) begin errors++; $display("FAIL reset_control: got %h want 0000", control); end
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_flags: halted=%b illegal=%b want 0 0", halted, illegal);
    end
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    reset = 1'b0;
    step();
    checks++;
    if (control !== 16'h0000 || state_o !== 4'd0) begin
      errors++; $display("FAIL idle_hold: control=%h state=%0d want 0000 0", control, state_o);
    end
  endtask

  task automatic test_ldac();
    logic [15:0] exp_seq [6];
    int inc_cnt;
    int ac_cnt;
    exp_seq = '{16'h0316, 16'h0000, 16'h0116, 16'h0025, 16'h0842, 16'h0316};
    inc_cnt = 0;
    ac_cnt  = 0;
    ir_out = 8'h01;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (control !== exp_seq[i]) begin
        errors++; $display("FAIL ldac_seq[%0d]: got %h want %h", i, control, exp_seq[i]);
      end
      if (i < 5) begin
        inc_cnt += int'(control[8]);
        ac_cnt  += int'(control[6]);
      end
    end
    checks++;
    if (inc_cnt != 2 || ac_cnt != 1) begin
      errors++; $display("FAIL ldac_counts: pc_inc=%0d ac_ld=%0d want 2 1", inc_cnt, ac_cnt);
    end
  endtask

  task automatic test_stac();
    logic [15:0] exp_seq [5];
    int wr_cnt;
    exp_seq = '{16'h0000, 16'h0116, 16'h0024, 16'h1002, 16'h0316};
    wr_cnt  = 0;
    ir_out  = 8'h02;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (control !== exp_seq[i]) begin
        errors++; $display("FAIL stac_seq[%0d]: got %h want %h", i, control, exp_seq[i]);
      end
      wr_cnt += int'(control[12]);
    end
    checks++;
    if (wr_cnt != 1) begin errors++; $display("FAIL stac_write_count: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_exec();
    logic [7:0]  ops  [5];
    logic [15:0] exps [5];
    ops  = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    exps = '{16'h000C, 16'h0843, 16'h0043, 16'h0443, 16'h0C40};
    for (int i = 0; i < 5; i++) begin
      ir_out = ops[i];
      step();
      checks++;
      if (control !== 16'h0000) begin errors++; $display("FAIL exec_decode[%h]: got %h want 0000", ops[i], control); end
      step();
      checks++;
      if (control !== exps[i]) begin errors++; $display("FAIL exec[%h]: got %h want %h", ops[i], control, exps[i]); end
      step();
      checks++;
      if (control !== 16'h0316) begin errors++; $display("FAIL exec_refetch[%h]: got %h want 0316", ops[i], control); end
    end
  endtask

  task automatic test_jmp();
    logic [7:0]  ops  [3];
    logic        zs   [3];
    logic [15:0] exps [3];
    ops  = '{8'h08, 8'h09, 8'h09};
    zs   = '{1'b0, 1'b1, 1'b0};
    exps = '{16'h0086, 16'h0086, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      ir_out = ops[i];
      z      = zs[i];
      step();
      checks++;
      if (control !== 16'h0000) begin errors++; $display("FAIL jmp_decode[%0d]: got %h want 0000", i, control); end
      step();
      checks++;
      if (control !== exps[i]) begin errors++; $display("FAIL jmp[%0d]: got %h want %h", i, control, exps[i]); end
      step();
      checks++;
      if (control !== 16'h0316) begin errors++; $display("FAIL jmp_refetch[%0d]: got %h want 0316", i, control); end
    end
    z = 1'b0;
  endtask

  task automatic test_illegal();
    ir_out = 8'h55;
    step();
    checks++;
    if (control !== 16'h0000 || illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_decode: control=%h illegal=%b want 0000 0", control, illegal);
    end
    step();
    checks++;
    if (control !== 16'h0316 || illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse: control=%h illegal=%b want 0316 1", control, illegal);
    end
    ir_out = 8'h00;
    step();
    checks++;
    if (control !== 16'h0000 || illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_one_cycle: control=%h illegal=%b want 0000 0", control, illegal);
    end
    step();
    checks++;
    if (control !== 16'h0316 || illegal !== 1'b0) begin
      errors++; $display("FAIL nop_refetch: control=%h illegal=%b want 0316 0", control, illegal);
    end
  endtask

  task automatic test_halt();
    ir_out = 8'hFF;
    step();
    step();
    checks++;
    if (halted !== 1'b1 || control !== 16'h0000) begin
      errors++; $display("FAIL halt_enter: halted=%b control=%h want 1 0000", halted, control);
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (halted !== 1'b1 || control !== 16'h0000) begin
        errors++; $display("FAIL halt_hold[%0d]: halted=%b control=%h want 1 0000", i, halted, control);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir_out = 8'h01;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    step();
    checks++;
    if (control !== 16'h0025) begin errors++; $display("FAIL mid_ld2: got %h want 0025", control); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (control !== 16'h0000 || state_o !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: control=%h state=%0d halted=%b want 0000 0 0", control, state_o, halted);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (control !== 16'h0000 || state_o !== 4'd0) begin
      errors++; $display("FAIL mid_reset_idle: control=%h state=%0d want 0000 0", control, state_o);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (control !== 16'h0316) begin errors++; $display("FAIL mid_restart: got %h want 0316", control); end
  endtask

  task automatic test_wait_ldac();
    logic [15:0] exp_seq [10];
    exp_seq = '{16'h0000, 16'h0316, 16'h0000, 16'h0000, 16'h0116,
                16'h0000, 16'h0025, 16'h0842, 16'h0000, 16'h0316};
    do_reset();
    ir_out = 8'h01;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      checks++;
      if (control !== exp_seq[i]) begin
        errors++; $display("FAIL wait_ldac_seq[%0d]: got %h want %h", i, control, exp_seq[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    start  = 1'b0;
    ir_out = 8'h00;
    z      = 1'b0;
    test_reset();
`ifdef CU_WAIT_STATE_EN
    test_wait_ldac();
`else
    test_ldac();
    test_stac();
    test_exec();
    test_jmp();
    test_illegal();
    test_halt();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
